// File: rtl/seg_scan_capture_pkg.sv
// Shared seven-segment code table (a..g on bits 7..1, dp on bit 0, 1 = lit).
// The hex-to-segment encoder uses the same constants, so the table is defined once.
package seg_scan_capture_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'hFF;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'hFD;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Entry i holds the pattern for nibble value i.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  localparam int CNT_W = 8;

endpackage

// File: rtl/seg_scan_capture_seg_decode.sv
// Stateless segment-pattern decoder: exact 8-bit match (dp included) against the table.
module seg_decode
  import seg_scan_capture_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
    blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures the digits of a multiplexed seven-segment display: debounces each
// (an, seg) pair, decodes it to a nibble and flags complete frames.
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg,
  input  logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] hex_out,
  output logic [NDIG-1:0]   digit_valid,
  output logic              frame_done,
  output logic              code_err
);

  localparam int            IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] SC = CNT_W'(STABLE_CYC);

  logic [7:0]             seg_q, prev_seg;
  logic [NDIG-1:0]        an_q, prev_an, frame_mask;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   eligible, same, acc_nxt, acc_vld;
  logic [IW-1:0]          idx;
  logic [NDIG-1:0][3:0]   nib;
  logic [3:0]             dec_nib;
  logic                   dec_hit, dec_blank;

  // prev_* holds the accepted pattern while acc_vld is high, so decode works off it.
  seg_decode u_dec (
    .seg    (prev_seg),
    .nibble (dec_nib),
    .hit    (dec_hit),
    .blank  (dec_blank)
  );

  always_comb begin
    eligible = $onehot(an_q);
    same     = (cnt != '0) && (an_q == prev_an) && (seg_q == prev_seg);
    cnt_nxt  = '0;
    acc_nxt  = 1'b0;
    if (eligible) begin
      if (!same)            cnt_nxt = CNT_W'(1);
      else if (cnt == SC)   cnt_nxt = SC;
      else                  cnt_nxt = cnt + CNT_W'(1);
      // Fire only on the first arrival at SC within a run, including SC==1 restarts.
      acc_nxt = (cnt_nxt == SC) && !(same && (cnt == SC));
    end
  end

  // OR of masked indices: one-hot input, no priority chain.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++)
      idx = idx | (IW'(i) & {IW{prev_an[i]}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q       <= '0;
      an_q        <= '0;
      prev_seg    <= '0;
      prev_an     <= '0;
      cnt         <= '0;
      acc_vld     <= 1'b0;
      nib         <= '0;
      digit_valid <= '0;
      frame_mask  <= '0;
      code_err    <= 1'b0;
    end else begin
      seg_q   <= seg;
      an_q    <= an;
      cnt     <= cnt_nxt;
      acc_vld <= acc_nxt;
      if (eligible) begin
        prev_an  <= an_q;
        prev_seg <= seg_q;
      end
      if (acc_vld) begin
        if (dec_hit) begin
          nib[idx]         <= dec_nib;
          digit_valid[idx] <= 1'b1;
        end else begin
          digit_valid[idx] <= 1'b0;
          if (!dec_blank) code_err <= 1'b1;
        end
      end
      // A full mask lives for exactly one cycle; an acceptance that cycle seeds the next frame.
      if (&frame_mask)  frame_mask <= acc_vld ? prev_an : '0;
      else if (acc_vld) frame_mask <= frame_mask | prev_an;
    end
  end

  assign hex_out    = nib;
  assign frame_done = &frame_mask;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios with literal expectations plus
// randomized scanning checked every cycle against a run-length behavioural model.
module tb_seg_scan_capture;

  localparam int NDIG = 4;
  localparam int SC   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        seg = 8'h00;
  logic [NDIG-1:0]   an  = '0;
  logic [4*NDIG-1:0] hex_out;
  logic [NDIG-1:0]   digit_valid;
  logic              frame_done, code_err;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;

  always #5 clk = ~clk;

  seg_scan_capture #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .code_err    (code_err)
  );

  logic [7:0] codes [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                            8'hFE, 8'hF6, 8'hEE, 8'hFF, 8'h9C, 8'hFD, 8'h9E, 8'h8E};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] s);
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NDIG-1:0] a);
    int n = 0, d = -1;
    for (int i = 0; i < NDIG; i++) if (a[i]) begin n++; d = i; end
    return (n == 1) ? d : -1;
  endfunction

  // Model: run length of identical eligible pin samples; the sample that makes the
  // run reach SC produces an event whose effect is visible two edges later.
  typedef struct { bit v; int d; logic [7:0] s; } ev_t;
  logic [3:0]      m_nib [NDIG];
  logic [NDIG-1:0] m_vld, m_mask, last_an;
  logic [7:0]      last_seg;
  logic            m_err, m_fd;
  int              run_len;
  ev_t             ev1, ev2;

  always @(posedge clk) begin
    int d, k;
    if (rst) begin
      for (int i = 0; i < NDIG; i++) m_nib[i] = 4'h0;
      m_vld = '0; m_mask = '0; m_err = 1'b0; m_fd = 1'b0; run_len = 0;
      ev1.v = 1'b0; ev2.v = 1'b0;
    end else begin
      if (m_mask == '1) m_mask = '0;
      if (ev2.v) begin
        k = lookup(ev2.s);
        if (k >= 0) begin m_nib[ev2.d] = k[3:0]; m_vld[ev2.d] = 1'b1; end
        else begin m_vld[ev2.d] = 1'b0; if (ev2.s != 8'h00) m_err = 1'b1; end
        m_mask[ev2.d] = 1'b1;
      end
      m_fd = (m_mask == '1);
      ev2 = ev1;
      ev1.v = 1'b0;
      d = onehot_idx(an);
      if (d < 0) run_len = 0;
      else begin
        if (run_len > 0 && an == last_an && seg == last_seg) run_len++;
        else run_len = 1;
        last_an = an; last_seg = seg;
        if (run_len == SC) begin ev1.v = 1'b1; ev1.d = d; ev1.s = seg; end
      end
    end
  end

  always @(posedge clk) begin
    logic [4*NDIG-1:0] mh;
    #2;
    if (!rst) begin
      for (int i = 0; i < NDIG; i++) mh[4*i +: 4] = m_nib[i];
      chk("hex_out",     32'(hex_out),     32'(mh));
      chk("digit_valid", 32'(digit_valid), 32'(m_vld));
      chk("frame_done",  32'(frame_done),  32'(m_fd));
      chk("code_err",    32'(code_err),    32'(m_err));
      if (frame_done) fd_cnt++;
    end
  end

  task automatic hold(input logic [NDIG-1:0] a, input logic [7:0] s, input int n);
    an = a; seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    an = '0; seg = 8'h00; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int f0;
    @(negedge clk);
    chk("rst_hex",   32'(hex_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_fd",    32'(frame_done), 32'h0);
    chk("rst_err",   32'(code_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single digit latency
    hold(4'b0001, 8'hDA, 4);
    hold(4'b0000, 8'h00, 1);
    chk("lat_early_valid", 32'(digit_valid), 32'h0);
    hold(4'b0000, 8'h00, 1);
    chk("lat_hex0",  32'(hex_out[3:0]), 32'h2);
    chk("lat_valid", 32'(digit_valid), 32'h1);

    // Full frame
    do_reset();
    f0 = fd_cnt;
    hold(4'b0001, 8'hB6, 6);
    hold(4'b0010, 8'hFF, 6);
    hold(4'b0100, 8'hFD, 6);
    hold(4'b1000, 8'hFC, 6);
    hold(4'b0000, 8'h00, 3);
    chk("frame_hex",   32'(hex_out), 32'h0DB5);
    chk("frame_pulse", 32'(fd_cnt - f0), 32'd1);
    chk("frame_err",   32'(code_err), 32'h0);
    chk("frame_valid", 32'(digit_valid), 32'hF);

    // Interrupted run
    do_reset();
    hold(4'b0001, 8'hDA, 3);
    hold(4'b0001, 8'hF2, 4);
    hold(4'b0000, 8'h00, 3);
    chk("short_hex0",  32'(hex_out[3:0]), 32'h3);
    chk("short_valid", 32'(digit_valid), 32'h1);

    // Miss keeps nibble, sets sticky error; blank does not clear it
    do_reset();
    hold(4'b0010, 8'hF6, 5);
    hold(4'b0010, 8'hA5, 4);
    hold(4'b0000, 8'h00, 3);
    chk("miss_err",   32'(code_err), 32'h1);
    chk("miss_valid", 32'(digit_valid[1]), 32'h0);
    chk("miss_nib1",  32'(hex_out[7:4]), 32'h9);
    hold(4'b0010, 8'h00, 5);
    hold(4'b0000, 8'h00, 3);
    chk("blank_sticky", 32'(code_err), 32'h1);

    // Blank alone: miss without error
    do_reset();
    hold(4'b0001, 8'hDA, 5);
    hold(4'b0001, 8'h00, 5);
    hold(4'b0000, 8'h00, 3);
    chk("blank_err",   32'(code_err), 32'h0);
    chk("blank_valid", 32'(digit_valid), 32'h0);
    chk("blank_nib0",  32'(hex_out[3:0]), 32'h2);

    // Ineligible digit selects
    do_reset();
    f0 = fd_cnt;
    hold(4'b0011, 8'hFC, 10);
    hold(4'b0000, 8'hFC, 10);
    hold(4'b0000, 8'h00, 2);
    chk("inel_hex",   32'(hex_out), 32'h0);
    chk("inel_valid", 32'(digit_valid), 32'h0);
    chk("inel_fd",    32'(fd_cnt - f0), 32'd0);

    // Reset mid-run
    do_reset();
    hold(4'b0001, 8'hDA, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hex", 32'(hex_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_early_valid", 32'(digit_valid), 32'h0);
    chk("mid_early_hex",   32'(hex_out), 32'h0);
    @(negedge clk);
    chk("mid_valid", 32'(digit_valid), 32'h1);
    chk("mid_hex0",  32'(hex_out[3:0]), 32'h2);

    // Randomized scanning
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [NDIG-1:0] a;
      logic [7:0] s;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) a = '0;
      else if (r == 1) begin
        a = NDIG'($urandom_range(0, 15));
        if ($countones(a) < 2) a = '1;
      end else begin
        a = '0;
        a[$urandom_range(0, NDIG-1)] = 1'b1;
      end
      r = $urandom_range(0, 11);
      if (r == 0) s = 8'h00;
      else if (r == 1) s = 8'($urandom());
      else s = codes[$urandom_range(0, 15)];
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      hold(a, s, $urandom_range(1, 7));
    end
    hold('0, 8'h00, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
